jk_bank_ctrl: RTL and testbench
===============================

# jk_bank_ctrl

Command-driven controller that sequences a bank of WIDTH JK flip-flops. It turns a small op set into per-bit J/K drive each cycle: clear, load, toggle-mask, and multi-cycle count up/down by N steps. The block sits between a command source (valid/ready handshake) and the JK register bank it owns. It is the standard way the sequential-circuits set builds counters and registers from JK cells.

## Interface
- WIDTH, default 4: number of JK cells in the bank; also the width of cmd_arg.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller accepts a command this cycle.
- cmd_op  input  3  opcode.
- cmd_arg  input  WIDTH  operand: load value, toggle mask, or step count.
- hold  input  1  pauses a running count; J=K=0 to all cells.
- q  output  WIDTH  bank state.
- qbar  output  WIDTH  always ~q.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse coincident with done for a reserved opcode.

## Operation
- Opcodes:
  - 0 NOP.
  - 1 CLEAR: J=0, K=1 on all bits.
  - 2 LOAD: J=arg, K=~arg.
  - 3 TOGGLE: J=K=arg.
  - 4 UP: N=arg steps.
  - 5 DOWN: N=arg steps.
  - 6–7 reserved: executed as NOP with err.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: cmd_ready=1. On cmd_valid, latch op/arg, set remaining=arg, go to EXEC.
  - EXEC: drive J/K. Single-cycle ops (NOP, CLEAR, LOAD, TOGGLE, reserved) spend 1 cycle, then go to DONE.
  - UP/DOWN: each non-hold EXEC cycle is one step and decrements remaining. Leave to DONE when remaining reaches 0 after a step.
  - UP/DOWN with arg=0: go IDLE→DONE directly; q unchanged.
  - DONE: done=1, err as applicable; next state IDLE.
- Per-step J/K for counting:
  - UP: bit i gets J=K=&q[i-1:0]; bit 0 always toggles.
  - DOWN: bit i gets J=K=&qbar[i-1:0]; bit 0 always toggles.
  - Wrap is modulo 2^WIDTH: UP from all-ones gives 0; DOWN from 0 gives all-ones.
- hold:
  - Honoured only in EXEC for UP/DOWN. When high, J=K=0 and remaining is unchanged.
  - Ignored for single-cycle ops and in IDLE/DONE.
- Outside EXEC, all cells get J=K=0 (q holds).
- busy=1 in EXEC and DONE.
- cmd_op/cmd_arg are don't-care unless cmd_valid && cmd_ready.

## Timing
- Reset (async assert, rst_n low):
  - q=0, qbar=all ones, state IDLE.
  - busy=0, done=0, err=0, cmd_ready=1.
  - A reset during EXEC aborts the op; no done is produced.
- Release is synchronous to clk; the first accept is possible on the first rising edge with rst_n high.
- Accept at edge t.
- Single-cycle op:
  - q updates at edge t+1.
  - done is high during cycle t+1→t+2.
  - cmd_ready is high again from edge t+2.
- UP/DOWN with N>0 and no hold:
  - q updates at edges t+1..t+N.
  - done is high during the cycle after edge t+N.
  - Each hold cycle adds one cycle of latency.
- cmd_ready=0 in EXEC and DONE. No back-to-back accept; minimum command spacing is 2 cycles.
- done/err are registered, never combinational from inputs.

## Structure
- Package jk_ctrl_pkg holds:
  - the opcode constants (OP_NOP…OP_DOWN);
  - FSM state encoding (IDLE, EXEC, DONE);
  - the reserved-opcode predicate.
- Sub-module jk_cell is one JK flip-flop with async active-low reset to q=0:
  - hold (00), reset (01), set (10), toggle (11);
  - instantiated WIDTH times via generate.
- The controller contains only the FSM, the remaining-step counter (WIDTH bits), and J/K decode.

## Test plan
- Reset, then LOAD arg=4'b1010 → q=1010 at edge t+1, qbar=0101, done pulse 1 cycle, err=0.
- From q=1010, TOGGLE arg=4'b0110 → q=1100; then CLEAR → q=0000.
- From q=1110, UP arg=3 → q sequence 1111, 0000, 0001 at edges t+1..t+3 (wrap); done at cycle after t+3.
- From q=0001, DOWN arg=2 with hold high for 2 cycles after the first step → q=0000, hold (q held 2 cycles), 1111; done 2 cycles later than the no-hold case.
- UP arg=0 → q unchanged, done one cycle after accept. Opcode 7 → q unchanged, done and err both pulse.
- Assert rst_n low mid-way through UP arg=9 → q=0 immediately, no done; cmd_ready=1 after release. cmd_valid held high during busy → not accepted until IDLE.

Source files
------------

// File: rtl/jk_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// jk_ctrl_pkg
// Shared definitions for the JK bank controller:
//   - opcode constants OP_NOP..OP_DOWN (opcodes 6 and 7 are reserved)
//   - FSM state encoding (IDLE, EXEC, DONE)
//   - is_reserved(): true for opcodes that run as NOP and raise err
// ---------------------------------------------------------------------------
package jk_ctrl_pkg;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_CLEAR  = 3'd1;
   localparam logic [2:0] OP_LOAD   = 3'd2;
   localparam logic [2:0] OP_TOGGLE = 3'd3;
   localparam logic [2:0] OP_UP     = 3'd4;
   localparam logic [2:0] OP_DOWN   = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic is_reserved(input logic [2:0] op);
      return (op > OP_DOWN);
   endfunction

endpackage

// File: rtl/jk_cell.sv
// ---------------------------------------------------------------------------
// jk_cell
// One JK flip-flop.
//   {j,k} = 00 hold, 01 reset, 10 set, 11 toggle.
// Ports:
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset (q -> 0)
//   j, k  in  JK drive
//   q     out cell state
// ---------------------------------------------------------------------------
module jk_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/jk_bank_ctrl.sv
// ---------------------------------------------------------------------------
// jk_bank_ctrl
// Command-driven controller that owns a bank of WIDTH JK cells and turns
// clear / load / toggle-mask / count up-down-by-N commands into per-bit J/K
// drive each cycle.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cmd_valid    command present
//   cmd_ready    controller accepts a command this cycle (high only in IDLE)
//   cmd_op       opcode (see jk_ctrl_pkg)
//   cmd_arg      load value, toggle mask, or step count
//   hold         pauses a running UP/DOWN count
//   q, qbar      bank state and its complement
//   busy         command in progress (EXEC or DONE)
//   done         one-cycle completion pulse
//   err          pulses with done for a reserved opcode
//   dbg_state    current FSM state (state_e encoding)
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; op/arg are only sampled on that edge. cmd_ready
// is a pure function of the state register, so it never depends on
// cmd_valid in the same cycle.
// ---------------------------------------------------------------------------
module jk_bank_ctrl
   import jk_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   input  logic             hold,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [1:0]       dbg_state
);

   state_e           state;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] arg_r;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] tmask;
   logic             carry;
   logic             is_count;
   logic             acc_count;

   assign is_count  = (op_r == OP_UP) || (op_r == OP_DOWN);
   assign acc_count = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);

   // Ripple toggle mask for one count step: bit i toggles when every lower
   // bit is 1 (UP) or every lower bit is 0 (DOWN); bit 0 always toggles.
   always_comb begin
      tmask = '0;
      carry = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         tmask[i] = carry;
         if (op_r == OP_DOWN) carry = carry & ~q[i];
         else                 carry = carry & q[i];
      end
   end

   // J/K decode. Everything outside EXEC leaves the bank untouched.
   always_comb begin
      j = '0;
      k = '0;
      if (state == EXEC) begin
         case (op_r)
            OP_CLEAR: begin
               k = '1;
            end
            OP_LOAD: begin
               j = arg_r;
               k = ~arg_r;
            end
            OP_TOGGLE: begin
               j = arg_r;
               k = arg_r;
            end
            OP_UP, OP_DOWN: begin
               if (!hold) begin
                  j = tmask;
                  k = tmask;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         op_r  <= OP_NOP;
         arg_r <= '0;
         rem_r <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  op_r  <= cmd_op;
                  arg_r <= cmd_arg;
                  rem_r <= cmd_arg;
                  // A zero-length count has nothing to execute.
                  if (acc_count && (cmd_arg == '0)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= EXEC;
                  end
               end
            end
            EXEC: begin
               if (is_count) begin
                  if (!hold) begin
                     rem_r <= rem_r - WIDTH'(1);
                     if (rem_r == WIDTH'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end
                  end
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
                  err   <= is_reserved(op_r);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      jk_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .j     (j[g]),
         .k     (k[g]),
         .q     (q[g])
      );
   end

   assign qbar      = ~q;
   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jk_bank_ctrl
// Self-checking bench for jk_bank_ctrl (WIDTH=4). Each command task builds
// the expected per-cycle {cmd_ready, busy, done, err, q} sequence from an
// arithmetic model of the bank and compares it cycle by cycle.
// ---------------------------------------------------------------------------
module tb_jk_bank_ctrl;
   import jk_ctrl_pkg::*;

   localparam int W  = 4;
   localparam int EW = W + 4;

   logic         clk;
   logic         rst_n;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [2:0]   cmd_op;
   logic [W-1:0] cmd_arg;
   logic         hold;
   logic [W-1:0] q;
   logic [W-1:0] qbar;
   logic         busy;
   logic         done;
   logic         err;
   logic [1:0]   dbg_state;

   logic [EW-1:0] exp_q[$];
   logic [W-1:0]  m_q;
   int            checks;
   int            failures;

   jk_bank_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .hold      (hold),
      .q         (q),
      .qbar      (qbar),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] count_step(input logic [2:0] op, input logic [W-1:0] v);
      return (op == OP_UP) ? v + W'(1) : v - W'(1);
   endfunction

   function automatic logic [W-1:0] apply_op(input logic [2:0] op, input logic [W-1:0] arg,
                                             input logic [W-1:0] v);
      case (op)
         OP_CLEAR:  return '0;
         OP_LOAD:   return arg;
         OP_TOGGLE: return v ^ arg;
         default:   return v;
      endcase
   endfunction

   // Drain exp_q, one entry per falling edge; hold_pat[c] drives hold during
   // cycle c after the accept edge. Called at the falling edge after accept.
   task automatic check_seq(input string name, input logic [7:0] hold_pat);
      logic [EW-1:0] e;
      logic [EW-1:0] obs;
      int            kc;
      kc = 0;
      while (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         obs = {cmd_ready, busy, done, err, q};
         checks++;
         if (obs !== e || qbar !== ~q) begin
            failures++;
            $display("FAIL %s cycle=%0d {rdy,busy,done,err,q} got=%b exp=%b qbar=%b", name, kc, obs, e, qbar);
         end
         hold = (kc < 8) ? hold_pat[kc] : 1'b0;
         kc++;
         if (exp_q.size() > 0) @(negedge clk);
      end
      hold = 1'b0;
   endtask

   // Driver + expected-sequence generation for one command. Enter at a negedge.
   task automatic run_cmd(input string name, input logic [2:0] op, input logic [W-1:0] arg,
                          input logic [7:0] hold_pat);
      int          waited;
      int          c;
      logic [W-1:0] rem;
      logic         cnt;
      waited = 0;
      while (!cmd_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (!cmd_ready) begin
         failures++;
         $display("FAIL %s ready_timeout got=%b exp=1", name, cmd_ready);
         return;
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      cnt = (op == OP_UP) || (op == OP_DOWN);
      if (cnt && arg == '0) begin
         exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b0, m_q});
      end else if (cnt) begin
         exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, m_q});
         rem = arg;
         c   = 0;
         while (rem != '0) begin
            if (c < 8 && hold_pat[c]) begin
               exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, m_q});
            end else begin
               m_q = count_step(op, m_q);
               rem = rem - W'(1);
               exp_q.push_back({1'b0, 1'b1, (rem == '0), 1'b0, m_q});
            end
            c++;
         end
      end else begin
         exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, m_q});
         m_q = apply_op(op, arg, m_q);
         exp_q.push_back({1'b0, 1'b1, 1'b1, (op > OP_DOWN), m_q});
      end
      exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, m_q});
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = $urandom_range(0, 7);
      cmd_arg   = $urandom_range(0, 15);
      check_seq(name, hold_pat);
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
      cmd_arg   = '0;
      hold      = 1'b0;
      m_q       = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({cmd_ready, busy, done, err, q, qbar} !== {4'b1000, 4'b0000, 4'b1111} ||
          dbg_state !== IDLE) begin
         failures++;
         $display("FAIL reset {rdy,busy,done,err,q,qbar} got=%b exp=100000001111 state=%0d",
                  {cmd_ready, busy, done, err, q, qbar}, dbg_state);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_load();
      run_cmd("load_1010", OP_LOAD, 4'b1010, 8'h00);
   endtask

   task automatic test_toggle_clear();
      run_cmd("toggle_0110", OP_TOGGLE, 4'b0110, 8'h00);
      run_cmd("clear", OP_CLEAR, 4'b1011, 8'hff);
   endtask

   task automatic test_up_wrap();
      run_cmd("load_1110", OP_LOAD, 4'b1110, 8'h00);
      run_cmd("up_3_wrap", OP_UP, 4'd3, 8'h00);
   endtask

   task automatic test_down_hold();
      run_cmd("down_2_hold", OP_DOWN, 4'd2, 8'b0000_0110);
   endtask

   task automatic test_zero_reserved();
      run_cmd("up_0", OP_UP, 4'd0, 8'h00);
      run_cmd("down_0", OP_DOWN, 4'd0, 8'h00);
      run_cmd("op7", 3'd7, 4'b0101, 8'h00);
      run_cmd("op6", 3'd6, 4'b1111, 8'h00);
      run_cmd("nop", OP_NOP, 4'b1111, 8'h01);
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         run_cmd("random", 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)));
      end
   endtask

   task automatic test_reset_mid();
      run_cmd("load_0011", OP_LOAD, 4'b0011, 8'h00);
      cmd_valid = 1'b1;
      cmd_op    = OP_UP;
      cmd_arg   = 4'd9;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q !== m_q || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_count step=%0d q got=%b exp=%b busy=%b", i, q, m_q, busy);
         end
         @(negedge clk);
         m_q = m_q + W'(1);
      end
      #2 rst_n = 1'b0;
      #1;
      m_q = '0;
      checks++;
      if (q !== 4'b0000 || qbar !== 4'b1111 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_async q got=%b exp=0000 qbar=%b busy=%b done=%b rdy=%b",
                  q, qbar, busy, done, cmd_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || q !== m_q || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_after cycle=%0d done got=%b exp=0 q=%b rdy=%b", i, done, q, cmd_ready);
         end
      end
   endtask

   // cmd_valid stays high through busy: accepts only land when IDLE, so a
   // TOGGLE repeats every 3 cycles.
   task automatic test_back_to_back();
      int          r;
      int          n;
      logic [W-1:0] q0;
      q0        = m_q;
      cmd_valid = 1'b1;
      cmd_op    = OP_TOGGLE;
      cmd_arg   = 4'b1111;
      for (int kc = 0; kc < 9; kc++) begin
         r = kc % 3;
         n = kc / 3 + ((r >= 1) ? 1 : 0);
         exp_q.push_back({(r == 2), (r != 2), (r == 1), 1'b0, (n % 2 == 1) ? ~q0 : q0});
      end
      @(posedge clk);
      for (int kc = 0; kc < 9; kc++) begin
         logic [EW-1:0] e;
         @(negedge clk);
         e = exp_q.pop_front();
         if (kc == 8) cmd_valid = 1'b0;
         checks++;
         if ({cmd_ready, busy, done, err, q} !== e) begin
            failures++;
            $display("FAIL back_to_back cycle=%0d {rdy,busy,done,err,q} got=%b exp=%b",
                     kc, {cmd_ready, busy, done, err, q}, e);
         end
      end
      m_q = ~q0;
      run_cmd("after_b2b_nop", OP_NOP, 4'b0000, 8'h00);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      @(negedge clk);
      test_load();
      test_toggle_clear();
      test_up_wrap();
      test_down_hold();
      test_zero_reserved();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
